// File: rtl/spi_memory_param.sv
// spi_memory_param: SPI mode-0 slave onto a 2**ADDR_W x DATA_W memory.
// Frame: ADDR_W addr bits, R/W bit (1=read), DATA_W data bits, all MSB first.
// Optional macro SPI_MEMORY_BURST_EN: auto-increment and continue while cs low.
module spi_memory_param #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sclk_pin,
    input  logic cs_pin,
    input  logic mosi_pin,
    output logic miso_pin,
    output logic miso_oe,
    output logic busy
);
    localparam int MAXB  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CW    = $clog2(MAXB + 1);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE, ADDR, RW, READ_LOAD, READ_SHIFT,
        WRITE_SHIFT, WRITE_COMMIT, HOLD
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   rise, fall, cs_fall;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sr;
    logic [CW-1:0]     cnt;
    logic              lead;
    logic              wr_en;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_prev;
    assign fall    = ~sclk_s & sclk_prev;
    assign cs_fall = ~cs_s & cs_prev;

    assign busy     = ~cs_s;
    assign miso_pin = miso_oe & sr[DATA_W-1];
    assign wr_en    = (state == WRITE_COMMIT) && !cs_s;

    // Bring the SPI pins into the clk domain; keep one extra sample for edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pin};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_pin};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    // Storage array; deliberately not reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= sr;
    end

    // Transaction FSM; cs high wins over any sclk edge in the same cycle.
    // The first fall after the R/W bit only closes that bit, so it is skipped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr    <= '0;
            sr      <= '0;
            cnt     <= '0;
            lead    <= 1'b0;
            miso_oe <= 1'b0;
        end else if (cs_s && state != IDLE) begin
            state   <= IDLE;
            cnt     <= '0;
            lead    <= 1'b0;
            miso_oe <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state <= ADDR;
                        cnt   <= '0;
                    end
                end
                ADDR: begin
                    if (rise) begin
                        addr <= {addr[ADDR_W-2:0], mosi_s};
                        if (cnt == CW'(ADDR_W - 1)) begin
                            cnt   <= '0;
                            state <= RW;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RW: begin
                    if (rise) begin
                        if (mosi_s) begin
                            state <= READ_LOAD;
                            lead  <= 1'b1;
                        end else begin
                            state <= WRITE_SHIFT;
                        end
                    end
                end
                READ_LOAD: begin
                    sr      <= mem[addr];
                    cnt     <= '0;
                    miso_oe <= 1'b1;
                    state   <= READ_SHIFT;
                end
                READ_SHIFT: begin
                    if (fall) begin
                        if (lead) begin
                            lead <= 1'b0;
                        end else begin
                            sr <= sr << 1;
                            if (cnt == CW'(DATA_W - 1)) begin
                                cnt     <= '0;
                                miso_oe <= 1'b0;
`ifdef SPI_MEMORY_BURST_EN
                                addr    <= addr + 1'b1;
                                state   <= READ_LOAD;
`else
                                state   <= HOLD;
`endif
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                end
                WRITE_SHIFT: begin
                    if (rise) begin
                        sr <= {sr[DATA_W-2:0], mosi_s};
                        if (cnt == CW'(DATA_W - 1)) begin
                            cnt   <= '0;
                            state <= WRITE_COMMIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WRITE_COMMIT: begin
`ifdef SPI_MEMORY_BURST_EN
                    addr  <= addr + 1'b1;
                    state <= WRITE_SHIFT;
`else
                    state <= HOLD;
`endif
                end
                HOLD: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_memory_param.md
SPI_MEMORY_PARAM -- requirements
Module: spi_memory_param

Interface
REQ-001 Parameter ADDR_W, default 7, address width in bits; memory depth SHALL be 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 8, word width in bits.
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser flops per SPI input (legal range 2..3).
REQ-004 clk  input  1  system clock; all state SHALL change only on its rising edge or on reset.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sclk_pin  input  1  SPI serial clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-007 cs_pin  input  1  chip select, active low.
REQ-008 mosi_pin  input  1  serial data in, MSB first.
REQ-009 miso_pin  output  1  serial data out, MSB first.
REQ-010 miso_oe  output  1  high while the block drives miso_pin with read data.
REQ-011 busy  output  1  high while cs_pin (synchronised) is low.

Function
REQ-012 sclk_pin, cs_pin and mosi_pin SHALL each pass through SYNC_STAGES flops; sclk rise and fall SHALL be detected by comparing the last two synchronised samples.
REQ-013 The design SHALL be correct for an sclk high time and low time of at least 4 clk cycles each.
REQ-014 FSM states: IDLE, ADDR, RW, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_COMMIT, HOLD.
REQ-015 IDLE -> ADDR on the synchronised cs falling edge; the bit counter SHALL clear.
REQ-016 ADDR: shift in ADDR_W address bits, MSB first, one per sclk rise; then RW.
REQ-017 RW: on the next sclk rise, mosi=1 selects read (-> READ_LOAD) and mosi=0 selects write (-> WRITE_SHIFT).
REQ-018 READ_LOAD SHALL last exactly 1 clk, copy mem[addr] into the DATA_W shift register, then -> READ_SHIFT.
REQ-019 READ_SHIFT: miso_pin SHALL present the shift-register MSB; the register SHALL shift left on each sclk fall; miso_oe=1; after DATA_W falls -> next-word decision (REQ-022).
REQ-020 WRITE_SHIFT: shift in DATA_W bits on sclk rises; then -> WRITE_COMMIT.
REQ-021 WRITE_COMMIT SHALL last exactly 1 clk and write the assembled word to mem[addr]; then -> next-word decision.
REQ-022 Next-word decision: behaviour is set by BURST_EN (see Configuration).
REQ-023 Address increment SHALL wrap modulo 2**ADDR_W (max address -> 0).
REQ-024 cs_pin high (synchronised) in any state SHALL force IDLE within 1 clk and abort the current word; a partial write word SHALL NOT be committed; miso_oe SHALL drop.
REQ-025 When miso_oe=0, miso_pin SHALL be 0.
REQ-026 A cs edge and an sclk edge detected in the same clk SHALL be resolved in favour of cs.
REQ-027 sclk edges in IDLE SHALL be ignored.

Reset
REQ-028 reset_n low SHALL immediately set: FSM=IDLE, counters=0, shift and address registers=0, miso_pin=0, miso_oe=0, busy=0, synchroniser flops=idle levels (sclk 0, cs 1, mosi 0).
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 Reset assertion mid-transaction SHALL abort it with no memory write; after release, the block SHALL wait for a fresh cs falling edge.

Configuration
REQ-031 Macro SPI_MEMORY_BURST_EN: when defined, after each word the address SHALL increment and the same operation SHALL continue (READ_LOAD or WRITE_SHIFT) while cs stays low.
REQ-032 When SPI_MEMORY_BURST_EN is undefined, after one word -> HOLD, which SHALL ignore all sclk edges, keep miso_oe=0 and exit to IDLE only on cs high.

Verification
REQ-033 Write addr 0x05 data 0xA5, cs high, then read addr 0x05 -> miso shifts out 1010_0101, miso_oe high for exactly 8 sclk falls.
REQ-034 Burst (macro on): write at 0x7F data 0x11,0x22 -> mem[0x7F]=0x11, mem[0x00]=0x22 (wrap); a burst read from 0x7F returns 0x11 then 0x22.
REQ-035 Macro off: write 0x33 at 0x10 followed by 8 extra sclk with mosi=1 -> mem[0x10]=0x33, mem[0x11] unchanged, state HOLD until cs high.
REQ-036 Raise cs after 4 of 8 data bits of a write to 0x20 (previous value 0x5A) -> mem[0x20] stays 0x5A, FSM=IDLE, busy=0.
REQ-037 Assert reset_n mid-read -> miso_pin=0 and miso_oe=0 in the same cycle; memory unchanged; next full transaction succeeds.
REQ-038 Rerun REQ-033 with ADDR_W=4, DATA_W=16, sclk high/low time 4 clk -> 16-bit word 0xBEEF written and read back correctly.
